mfcc_melbank_ctrl: RTL and testbench



---
 rtl/mfcc_melbank_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_mfcc_melbank_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mfcc_melbank_ctrl.sv
// Mel filterbank controller: walks each filter row, multiply-accumulates
// spectrum power by ROM weight, and hands one energy per filter downstream.
module mfcc_melbank_ctrl #(
    parameter int NUM_FILT   = 4,
    parameter int NUM_BIN    = 16,
    parameter int PWR_WIDTH  = 16,
    parameter int COEF_WIDTH = 8,
    parameter int ROM_LAT    = 0,
    localparam int ROM_AW    = $clog2(NUM_FILT * NUM_BIN),
    localparam int BIN_AW    = (NUM_BIN > 1) ? $clog2(NUM_BIN) : 1,
    localparam int IDX_W     = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1,
    localparam int ACC_WIDTH = PWR_WIDTH + COEF_WIDTH + BIN_AW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_AW-1:0]     spec_addr,
    input  logic [PWR_WIDTH-1:0]  spec_data,
    output logic [ROM_AW-1:0]     rom_addr,
    input  logic [COEF_WIDTH-1:0] rom_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_data,
    output logic [IDX_W-1:0]      out_idx
);

    localparam int PROD_W = PWR_WIDTH + COEF_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_OUT
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      filt_q, filt_d;
    logic [BIN_AW-1:0]     bin_q, bin_d;
    logic [1:0]            drain_q, drain_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0]  out_data_q, out_data_d;
    logic [IDX_W-1:0]      out_idx_q, out_idx_d;
    logic [BIN_AW-1:0]     spec_addr_q, spec_addr_d;
    logic [ROM_AW-1:0]     rom_addr_q, rom_addr_d;

    logic                  v1_q, v1_d;
    logic                  v2_q, v2_d;
    logic [COEF_WIDTH-1:0] rom_q, rom_d;
    logic [COEF_WIDTH-1:0] coef;
    logic [PROD_W-1:0]     prod_q, prod_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic                  acc_clear;

    // A combinational ROM is registered once so both operands line up one
    // cycle after their address, matching the spectrum buffer.
    assign coef = (ROM_LAT == 1) ? rom_data : rom_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned; that is what keeps this block free of inferred latches.
        state_d     = state_q;
        filt_d      = filt_q;
        bin_d       = bin_q;
        drain_d     = drain_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        spec_addr_d = spec_addr_q;
        rom_addr_d  = rom_addr_q;
        acc_clear   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_FETCH;
                    filt_d    = '0;
                    bin_d     = '0;
                    busy_d    = 1'b1;
                    acc_clear = 1'b1;
                end
            end
            ST_FETCH: begin
                if (bin_q == BIN_AW'(NUM_BIN - 1)) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else begin
                    bin_d = bin_q + BIN_AW'(1);
                end
            end
            ST_DRAIN: begin
                // Three cycles cover the ROM-align, product and accumulate stages.
                if (drain_q == 2'd2) begin
                    state_d     = ST_OUT;
                    out_valid_d = 1'b1;
                    out_data_d  = acc_q;
                    out_idx_d   = filt_q;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (filt_q == IDX_W'(NUM_FILT - 1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d   = ST_FETCH;
                        filt_d    = filt_q + IDX_W'(1);
                        bin_d     = '0;
                        acc_clear = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Addresses are registered outputs, so they are loaded with the bin
        // that will be current in the next FETCH cycle and held otherwise.
        if (state_d == ST_FETCH) begin
            spec_addr_d = bin_d;
            rom_addr_d  = ROM_AW'(filt_d) * ROM_AW'(NUM_BIN) + ROM_AW'(bin_d);
        end

        v1_d   = (state_q == ST_FETCH);
        v2_d   = v1_q;
        rom_d  = rom_data;
        prod_d = PROD_W'(spec_data) * PROD_W'(coef);
        if (acc_clear) begin
            acc_d = '0;
        end else if (v2_q) begin
            acc_d = acc_q + ACC_WIDTH'(prod_q);
        end else begin
            acc_d = acc_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            filt_q      <= '0;
            bin_q       <= '0;
            drain_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            spec_addr_q <= '0;
            rom_addr_q  <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            rom_q       <= '0;
            prod_q      <= '0;
            acc_q       <= '0;
        end else begin
            state_q     <= state_d;
            filt_q      <= filt_d;
            bin_q       <= bin_d;
            drain_q     <= drain_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            spec_addr_q <= spec_addr_d;
            rom_addr_q  <= rom_addr_d;
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            rom_q       <= rom_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign spec_addr = spec_addr_q;
    assign rom_addr  = rom_addr_q;

endmodule

// File: tb/tb_mfcc_melbank_ctrl.sv
// Bench for mfcc_melbank_ctrl: two instances (combinational and registered ROM)
// share stimulus and must produce identical results and timing.
module tb_mfcc_melbank_ctrl;

    localparam int NF  = 2;
    localparam int NB  = 4;
    localparam int PW  = 16;
    localparam int CW  = 8;
    localparam int RAW = 3;
    localparam int BAW = 2;
    localparam int IW  = 1;
    localparam int AW  = PW + CW + BAW;

    typedef struct packed {
        logic [0:NB-1][PW-1:0]    spec;
        logic [0:NF*NB-1][CW-1:0] wt;
        logic [AW-1:0]            e0;
        logic [AW-1:0]            e1;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n, start, out_ready;
    logic [1:0]          busy, done, ov;
    logic [1:0][BAW-1:0] sa;
    logic [1:0][RAW-1:0] ra;
    logic [1:0][PW-1:0]  sd;
    logic [1:0][CW-1:0]  rd, rd_q;
    logic [1:0][AW-1:0]  od;
    logic [1:0][IW-1:0]  oi;

    logic [PW-1:0] spec_mem [NB];
    logic [CW-1:0] rom_mem [NF*NB];

    int passed = 0;
    int total  = 0;
    vec_t vecs [4];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        mfcc_melbank_ctrl #(
            .NUM_FILT(NF), .NUM_BIN(NB), .PWR_WIDTH(PW), .COEF_WIDTH(CW), .ROM_LAT(k)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start), .busy(busy[k]), .done(done[k]),
            .spec_addr(sa[k]), .spec_data(sd[k]), .rom_addr(ra[k]), .rom_data(rd[k]),
            .out_valid(ov[k]), .out_ready(out_ready), .out_data(od[k]), .out_idx(oi[k])
        );

        always @(posedge clk) begin
            sd[k]   <= spec_mem[sa[k]];
            rd_q[k] <= rom_mem[ra[k]];
        end
        assign rd[k] = (k == 0) ? rom_mem[ra[k]] : rd_q[k];
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic load(input vec_t v);
        for (int i = 0; i < NB; i++) spec_mem[i] = v.spec[i];
        for (int i = 0; i < NF * NB; i++) rom_mem[i] = v.wt[i];
    endtask

    // One full frame with out_ready high; optional start pokes while busy.
    task automatic run_frame(input string tag, input logic [AW-1:0] e0,
                             input logic [AW-1:0] e1, input bit poke);
        int            hs [2];
        int            dcyc [2];
        int            cyc [2][2];
        logic [AW-1:0] dat [2][2];
        logic [IW-1:0] idx [2][2];
        for (int k = 0; k < 2; k++) begin
            hs[k] = 0;
            dcyc[k] = -1;
            for (int h = 0; h < 2; h++) begin
                cyc[k][h] = -1;
                dat[k][h] = '0;
                idx[k][h] = '0;
            end
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'(2'b11));
        for (int j = 0; j <= 26; j++) begin
            if (j > 0) @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (ov[k] && out_ready) begin
                    if (hs[k] < 2) begin
                        dat[k][hs[k]] = od[k];
                        idx[k][hs[k]] = oi[k];
                        cyc[k][hs[k]] = j;
                    end
                    hs[k]++;
                end
                if (done[k] && dcyc[k] < 0) dcyc[k] = j;
            end
            start = poke && (j == 3 || j == 12);
        end
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_d%0d_count", tag, k), 64'(hs[k]), 64'd2);
            check($sformatf("%s_d%0d_data0", tag, k), 64'(dat[k][0]), 64'(e0));
            check($sformatf("%s_d%0d_idx0", tag, k), 64'(idx[k][0]), 64'd0);
            check($sformatf("%s_d%0d_cyc0", tag, k), 64'(cyc[k][0]), 64'd7);
            check($sformatf("%s_d%0d_data1", tag, k), 64'(dat[k][1]), 64'(e1));
            check($sformatf("%s_d%0d_idx1", tag, k), 64'(idx[k][1]), 64'd1);
            check($sformatf("%s_d%0d_cyc1", tag, k), 64'(cyc[k][1]), 64'd15);
            check($sformatf("%s_d%0d_done", tag, k), 64'(dcyc[k]), 64'd16);
        end
        check({tag, "_idle"}, 64'({busy, done}), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int first_cyc [2];
        int done_cyc [2];
        logic [AW-1:0] first_dat [2];
        logic [IW-1:0] first_idx [2];

        vecs[0].spec = {16'd1, 16'd1, 16'd1, 16'd1};
        vecs[0].wt   = {8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
        vecs[0].e0   = 26'd4;
        vecs[0].e1   = 26'd4;
        vecs[1].spec = {16'd1, 16'd2, 16'd3, 16'd4};
        vecs[1].wt   = {8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd2, 8'd1};
        vecs[1].e0   = 26'd1;
        vecs[1].e1   = 26'd10;
        vecs[2].spec = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        vecs[2].wt   = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vecs[2].e0   = 26'h3FBFC04;
        vecs[2].e1   = 26'h3FBFC04;
        vecs[3].spec = {16'd10, 16'd20, 16'd30, 16'd40};
        vecs[3].wt   = {8'd1, 8'd2, 8'd3, 8'd4, 8'd4, 8'd3, 8'd2, 8'd1};
        vecs[3].e0   = 26'd300;
        vecs[3].e1   = 26'd200;

        rst_n = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
        load(vecs[0]);
        #3;
        check("rst_ctrl", 64'({busy, done, ov}), 64'd0);
        check("rst_data", 64'(od), 64'd0);
        check("rst_idx", 64'(oi), 64'd0);
        check("rst_addr", 64'({sa, ra}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            load(vecs[i]);
            run_frame($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1, 1'b0);
        end

        // Back-pressure: result and addresses frozen while out_ready is low.
        load(vecs[1]);
        out_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        for (int s = 0; s < 5; s++) begin
            if (s > 0) @(negedge clk);
            check($sformatf("stall%0d_valid", s), 64'(ov), 64'(2'b11));
            check($sformatf("stall%0d_data", s), 64'(od), 64'({26'd1, 26'd1}));
            check($sformatf("stall%0d_idx", s), 64'(oi), 64'd0);
            check($sformatf("stall%0d_addr", s), 64'({sa, ra}), 64'({2'd3, 2'd3, 3'd3, 3'd3}));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        check("resume_valid", 64'(ov), 64'd0);
        check("resume_addr", 64'({sa, ra}), 64'({2'd0, 2'd0, 3'd4, 3'd4}));
        for (int k = 0; k < 2; k++) begin
            first_cyc[k] = -1;
            done_cyc[k] = -1;
            first_dat[k] = '0;
            first_idx[k] = '0;
        end
        for (int j = 14; j <= 30; j++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (ov[k] && first_cyc[k] < 0) begin
                    first_cyc[k] = j;
                    first_dat[k] = od[k];
                    first_idx[k] = oi[k];
                end
                if (done[k] && done_cyc[k] < 0) done_cyc[k] = j;
            end
        end
        for (int k = 0; k < 2; k++) begin
            check($sformatf("resume_d%0d_cyc", k), 64'(first_cyc[k]), 64'd20);
            check($sformatf("resume_d%0d_data", k), 64'(first_dat[k]), 64'd10);
            check($sformatf("resume_d%0d_idx", k), 64'(first_idx[k]), 64'd1);
            check($sformatf("resume_d%0d_done", k), 64'(done_cyc[k]), 64'd21);
        end

        // Reset in the middle of filter 1 FETCH abandons the frame.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("midrst_pre_addr", 64'({sa, ra}), 64'({2'd2, 2'd2, 3'd6, 3'd6}));
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ctrl", 64'({busy, done, ov}), 64'd0);
        check("midrst_data", 64'(od), 64'd0);
        check("midrst_addr", 64'({sa, ra}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (ov != 2'b00 || done != 2'b00 || busy != 2'b00) seen++;
        end
        check("midrst_quiet", 64'(seen), 64'd0);
        run_frame("post_rst", vecs[1].e0, vecs[1].e1, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
